// File: rtl/mcs_io_bridge.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mcs_io_bridge
// Description : Bridges the single-cycle IO strobes of a soft CPU (MicroBlaze
//               MCS style) onto a simple local bus of NUM_CH peripheral
//               channels.
//
//               mcs_addr[ADDR_W+2:ADDR_W] selects the channel, and
//               mcs_addr[ADDR_W-1:0] is the local address. The bridge issues
//               a one-cycle req with cs held one-hot. It waits for that
//               channel's rdy, then returns a one-cycle mcs_ready pulse.
//
//               An out-of-range channel completes at once with bus_err.
//
//               Optional macro MCS_IO_BRIDGE_TIMEOUT_EN adds a watchdog. It
//               aborts a transfer after TIMEOUT_CYC cycles without rdy, and
//               the aborted transfer returns all-ones with bus_err.
//
// Ports       : clk, reset             clock, async active-high reset
//               mcs_addr/rd_enable/wr_enable/wr_data/byte_enable  CPU side in
//               mcs_rd_data, mcs_ready CPU side out
//               addr, req, rnw, wr_data, cs   local bus out
//               rd_data, rdy           local bus in (packed per channel)
//               bus_err                error pulse, coincident with mcs_ready
//
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
module mcs_io_bridge #(
   parameter int NUM_CH      = 4,
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [31:0]              mcs_addr,
   input  logic                     mcs_rd_enable,
   input  logic                     mcs_wr_enable,
   input  logic [31:0]              mcs_wr_data,
   input  logic [3:0]               mcs_byte_enable,
   output logic [31:0]              mcs_rd_data,
   output logic                     mcs_ready,
   output logic [ADDR_W-1:0]        addr,
   output logic                     req,
   output logic                     rnw,
   output logic [DATA_W-1:0]        wr_data,
   output logic [NUM_CH-1:0]        cs,
   input  logic [NUM_CH*DATA_W-1:0] rd_data,
   input  logic [NUM_CH-1:0]        rdy,
   output logic                     bus_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   localparam logic [3:0] c_num_ch = 4'(NUM_CH);

   state_t              r_state;
   state_t              w_state_nxt;

   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wr_data;
   logic                r_rnw;
   logic [NUM_CH-1:0]   r_cs;
   logic                r_err;
   logic [31:0]         r_rd_data;

   logic                w_strobe;
   logic [2:0]          w_sel;
   logic                w_in_range;
   logic [NUM_CH-1:0]   w_cs_dec;
   logic                w_hit;
   logic [DATA_W-1:0]   w_sel_data;
   logic                w_timeout;
   logic                w_unused_ok;

   // Byte enables and the address/data bits above the decoded fields carry
   // no meaning here.
   assign w_unused_ok = ^{mcs_byte_enable, mcs_addr, mcs_wr_data};

   assign w_strobe   = mcs_rd_enable | mcs_wr_enable;
   assign w_sel      = mcs_addr[ADDR_W+2:ADDR_W];
   assign w_in_range = ({1'b0, w_sel} < c_num_ch);

   always_comb begin
      w_cs_dec = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         w_cs_dec[k] = (w_sel == 3'(k));
      end
   end

   // The registered one-hot cs acts as the selection mask. Other channels'
   // rdy and rd_data therefore never reach the response path.
   assign w_hit = |(rdy & r_cs);

   always_comb begin
      w_sel_data = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (r_cs[k]) begin
            w_sel_data = w_sel_data | rd_data[k*DATA_W +: DATA_W];
         end
      end
   end

`ifdef MCS_IO_BRIDGE_TIMEOUT_EN
   localparam int c_tmo_w = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic [c_tmo_w-1:0] c_tmo_max = c_tmo_w'(TIMEOUT_CYC);

   logic [c_tmo_w-1:0] r_tmo_cnt;

   // REQ is only ever entered from IDLE, so the count is cleared whenever
   // IDLE is occupied.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tmo_cnt <= '0;
      end else if (r_state == S_IDLE) begin
         r_tmo_cnt <= '0;
      end else if ((r_state == S_REQ || r_state == S_WAIT) && !w_timeout) begin
         r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
      end
   end

   assign w_timeout = (r_tmo_cnt == c_tmo_max);
`else
   localparam int c_unused_tmo = TIMEOUT_CYC;
   assign w_timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_strobe) begin
               w_state_nxt = w_in_range ? S_REQ : S_RESP;
            end
         end
         S_REQ, S_WAIT: begin
            if (w_hit || w_timeout) begin
               w_state_nxt = S_RESP;
            end else begin
               w_state_nxt = S_WAIT;
            end
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Transfer datapath. Everything is captured at the strobe and held
   // until RESP is left. The response word is written only on the edge
   // entering RESP, so mcs_rd_data holds between completions.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr    <= '0;
         r_wr_data <= '0;
         r_rnw     <= 1'b0;
         r_cs      <= '0;
         r_err     <= 1'b0;
         r_rd_data <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_strobe) begin
                  r_addr    <= mcs_addr[ADDR_W-1:0];
                  r_wr_data <= mcs_wr_data[DATA_W-1:0];
                  // A write wins when both strobes coincide.
                  r_rnw     <= ~mcs_wr_enable;
                  r_cs      <= w_in_range ? w_cs_dec : '0;
                  r_err     <= ~w_in_range;
                  if (!w_in_range) begin
                     r_rd_data <= '0;
                  end
               end
            end
            S_REQ, S_WAIT: begin
               if (w_hit) begin
                  r_rd_data <= r_rnw ? 32'(w_sel_data) : 32'd0;
               end else if (w_timeout) begin
                  r_rd_data <= 32'hFFFF_FFFF;
                  r_err     <= 1'b1;
               end
            end
            S_RESP: begin
               r_cs <= '0;
            end
            default: begin
               r_cs <= '0;
            end
         endcase
      end
   end

   assign mcs_ready   = (r_state == S_RESP);
   assign bus_err     = (r_state == S_RESP) & r_err;
   assign req         = (r_state == S_REQ);
   assign mcs_rd_data = r_rd_data;
   assign addr        = r_addr;
   assign rnw         = r_rnw;
   assign wr_data     = r_wr_data;
   assign cs          = r_cs;

endmodule
`default_nettype wire

// File: tb/tb_mcs_io_bridge.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_mcs_io_bridge
// Description : Self-checking bench for mcs_io_bridge.
//
//               A monitor pops the expected response from a scoreboard on
//               each mcs_ready pulse. Directed sequences check the local bus
//               timing inline.
//
//               With MCS_IO_BRIDGE_TIMEOUT_EN defined, the bench also covers
//               the watchdog abort.
//
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
module tb_mcs_io_bridge;

   localparam int NUM_CH = 4;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [31:0]              mcs_addr;
   logic                     mcs_rd_enable;
   logic                     mcs_wr_enable;
   logic [31:0]              mcs_wr_data;
   logic [3:0]               mcs_byte_enable;
   logic [31:0]              mcs_rd_data;
   logic                     mcs_ready;
   logic [ADDR_W-1:0]        addr;
   logic                     req;
   logic                     rnw;
   logic [DATA_W-1:0]        wr_data;
   logic [NUM_CH-1:0]        cs;
   logic [NUM_CH*DATA_W-1:0] rd_data;
   logic [NUM_CH-1:0]        rdy;
   logic                     bus_err;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   int n_tests = 0;
   int n_fail  = 0;
   int n_ready = 0;
   int n_req   = 0;

   always #5 clk = ~clk;

   mcs_io_bridge #(
      .NUM_CH      (NUM_CH),
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .mcs_addr        (mcs_addr),
      .mcs_rd_enable   (mcs_rd_enable),
      .mcs_wr_enable   (mcs_wr_enable),
      .mcs_wr_data     (mcs_wr_data),
      .mcs_byte_enable (mcs_byte_enable),
      .mcs_rd_data     (mcs_rd_data),
      .mcs_ready       (mcs_ready),
      .addr            (addr),
      .req             (req),
      .rnw             (rnw),
      .wr_data         (wr_data),
      .cs              (cs),
      .rd_data         (rd_data),
      .rdy             (rdy),
      .bus_err         (bus_err)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Called just after a falling edge; returns one cycle later with the
   // strobe removed (the bridge is then in REQ, or RESP for a bad channel).
   task automatic do_strobe(input logic [31:0] a, input logic rd, input logic wr,
                            input logic [31:0] d);
      mcs_addr      = a;
      mcs_rd_enable = rd;
      mcs_wr_enable = wr;
      mcs_wr_data   = d;
      @(negedge clk);
      mcs_rd_enable = 1'b0;
      mcs_wr_enable = 1'b0;
   endtask

   // Response monitor / scoreboard
   always @(negedge clk) begin
      if (req) n_req++;
      if (bus_err && !mcs_ready) check("err_without_ready", 32'(mcs_ready), 32'd1);
      if (mcs_ready) begin
         n_ready++;
         if (sb_q.size() == 0) begin
            check("unexpected_ready", 32'(sb_q.size()), 32'd1);
         end else begin
            mon_e = sb_q.pop_front();
            check("sb_rd_data", mcs_rd_data, mon_e.data);
            check("sb_bus_err", 32'(bus_err), 32'(mon_e.err));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int snap_req;
      int snap_ready;
      int k;

      reset           = 1'b1;
      mcs_addr        = '0;
      mcs_rd_enable   = 1'b0;
      mcs_wr_enable   = 1'b0;
      mcs_wr_data     = '0;
      mcs_byte_enable = 4'hF;
      rd_data         = '0;
      rdy             = '0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_mcs_ready", 32'(mcs_ready), 32'd0);
      check("rst_req",       32'(req),       32'd0);
      check("rst_rnw",       32'(rnw),       32'd0);
      check("rst_bus_err",   32'(bus_err),   32'd0);
      check("rst_cs",        32'(cs),        32'd0);
      check("rst_addr",      32'(addr),      32'd0);
      check("rst_wr_data",   32'(wr_data),   32'd0);
      check("rst_rd_data",   mcs_rd_data,    32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Write to channel 1, rdy in the REQ cycle
      sb_q.push_back('{data: 32'd0, err: 1'b0});
      do_strobe(32'h105, 1'b0, 1'b1, 32'h0000_00A5);
      check("wr_req",     32'(req),       32'd1);
      check("wr_cs",      32'(cs),        32'h2);
      check("wr_addr",    32'(addr),      32'h05);
      check("wr_data",    32'(wr_data),   32'hA5);
      check("wr_rnw",     32'(rnw),       32'd0);
      check("wr_early",   32'(mcs_ready), 32'd0);
      rdy = 4'b0010;
      @(negedge clk);
      rdy = '0;
      check("wr_ready_t2", 32'(mcs_ready), 32'd1);
      check("wr_cs_resp",  32'(cs),        32'h2);
      check("wr_req_once", 32'(req),       32'd0);
      @(negedge clk);
      check("wr_cs_idle",  32'(cs),        32'd0);
      check("wr_ready_1c", 32'(mcs_ready), 32'd0);

      // Read from channel 3, rdy five cycles after req; other channels
      // signal rdy throughout and must be ignored
      rd_data = {8'h3C, 8'hC3, 8'h99, 8'h55};
      sb_q.push_back('{data: 32'h0000_003C, err: 1'b0});
      do_strobe(32'h302, 1'b1, 1'b0, 32'hDEAD_BEEF);
      check("rd_req",  32'(req),  32'd1);
      check("rd_cs",   32'(cs),   32'h8);
      check("rd_rnw",  32'(rnw),  32'd1);
      check("rd_addr", 32'(addr), 32'h02);
      rdy = 4'b0111;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rd_wait_ready", 32'(mcs_ready), 32'd0);
         check("rd_wait_cs",    32'(cs),        32'h8);
      end
      rdy = 4'b1000;
      @(negedge clk);
      rdy = '0;
      check("rd_ready", 32'(mcs_ready), 32'd1);
      repeat (3) @(negedge clk);
      check("rd_hold", mcs_rd_data, 32'h0000_003C);

      // Out-of-range channel 6
      snap_req = n_req;
      sb_q.push_back('{data: 32'd0, err: 1'b1});
      do_strobe(32'h600, 1'b1, 1'b0, 32'd0);
      check("oor_ready_t1", 32'(mcs_ready), 32'd1);
      check("oor_bus_err",  32'(bus_err),   32'd1);
      check("oor_cs",       32'(cs),        32'd0);
      check("oor_req",      32'(req),       32'd0);
      @(negedge clk);
      check("oor_ready_1c", 32'(mcs_ready), 32'd0);
      check("oor_no_req",   32'(n_req),     32'(snap_req));

      // Simultaneous strobes, then a second strobe while waiting
      snap_ready = n_ready;
      sb_q.push_back('{data: 32'd0, err: 1'b0});
      do_strobe(32'h201, 1'b1, 1'b1, 32'h0000_005A);
      check("both_rnw", 32'(rnw),     32'd0);
      check("both_cs",  32'(cs),      32'h4);
      check("both_wd",  32'(wr_data), 32'h5A);
      @(negedge clk);
      snap_req = n_req;
      do_strobe(32'h100, 1'b1, 1'b0, 32'h0000_0011);
      @(negedge clk);
      check("ign_cs",   32'(cs),      32'h4);
      check("ign_addr", 32'(addr),    32'h01);
      check("ign_rnw",  32'(rnw),     32'd0);
      check("ign_wd",   32'(wr_data), 32'h5A);
      rdy = 4'b0100;
      @(negedge clk);
      rdy = '0;
      check("both_ready", 32'(mcs_ready), 32'd1);
      repeat (5) @(negedge clk);
      check("ign_no_req",    32'(n_req),   32'(snap_req));
      check("ign_one_ready", 32'(n_ready), 32'(snap_ready + 1));

      rd_data = {8'h3C, 8'hC3, 8'h99, 8'h77};
`ifdef MCS_IO_BRIDGE_TIMEOUT_EN
      // Channel 0 never answers: watchdog abort
      sb_q.push_back('{data: 32'hFFFF_FFFF, err: 1'b1});
      do_strobe(32'h010, 1'b1, 1'b0, 32'd0);
      k = 0;
      while (!mcs_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("tmo_ready", 32'(mcs_ready), 32'd1);
      @(negedge clk);
`endif
      // Hung read, then reset while in WAIT
      snap_ready = n_ready;
      do_strobe(32'h010, 1'b1, 1'b0, 32'd0);
`ifdef MCS_IO_BRIDGE_TIMEOUT_EN
      repeat (3) @(negedge clk);
`else
      repeat (1000) @(negedge clk);
`endif
      check("hang_cs",       32'(cs),      32'h1);
      check("hang_no_ready", 32'(n_ready), 32'(snap_ready));
      reset = 1'b1;
      #1;
      check("arst_cs",    32'(cs),        32'd0);
      check("arst_ready", 32'(mcs_ready), 32'd0);
      check("arst_req",   32'(req),       32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("arst_no_ready", 32'(n_ready),   32'(snap_ready));
      check("arst_rd_data",  mcs_rd_data,    32'd0);

      // Fresh read of channel 0 after reset
      sb_q.push_back('{data: 32'h0000_0077, err: 1'b0});
      do_strobe(32'h010, 1'b1, 1'b0, 32'd0);
      check("post_req", 32'(req),  32'd1);
      check("post_cs",  32'(cs),   32'h1);
      check("post_addr", 32'(addr), 32'h10);
      rdy = 4'b0001;
      @(negedge clk);
      rdy = '0;
      check("post_ready", 32'(mcs_ready), 32'd1);
      @(negedge clk);

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
